jpeg_block_scheduler: RTL and testbench
=======================================

# jpeg_block_scheduler

Sequences a full frame from the raster-order frame buffer into the JPEG encoder datapath as a series of 8x8 blocks. On a start pulse it generates frame-buffer read addresses block by block, re-times the returned pixels into a valid/last stream for the colour-convert → DCT → zig-zag → RLE chain, and holds off the next block until the chain reports the current block finished. It sits between the frame-buffer BRAM read port and the encoder's pixel input in the top level.

## Interface
Parameters:
- IMG_W, 320, image width in pixels; multiple of 8
- IMG_H, 240, image height in pixels; multiple of 8
- PIX_WIDTH, 24, frame-buffer word width (packed RGB)
- ADDR_WIDTH, 17, frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMG_W*IMG_H
- BRAM_LATENCY, 2, read latency of the frame buffer in cycles (≥1)

Ports:
- clk_in  in  1  single clock for the whole block
- rst_in  in  1  reset; synchronous, active-high
- start_in  in  1  one-cycle pulse; begins a frame when idle
- fb_addr_out  out  ADDR_WIDTH  frame-buffer read address
- fb_data_in  in  PIX_WIDTH  frame-buffer read data, valid BRAM_LATENCY cycles after address
- pixel_out  out  PIX_WIDTH  pixel to encoder datapath
- pixel_valid_out  out  1  pixel_out is valid this cycle
- pixel_last_out  out  1  high with the 64th pixel of a block
- block_done_in  in  1  pulse from downstream: current block fully consumed
- block_col_out  out  $clog2(IMG_W/8)  column index of block being sent
- block_row_out  out  $clog2(IMG_H/8)  row index of block being sent
- busy_out  out  1  high from accepted start until frame complete
- frame_done_out  out  1  one-cycle pulse after last block's block_done_in

## Operation
- States: IDLE, FETCH, DRAIN, WAIT_DONE.
- IDLE: start_in → FETCH, block_col=block_row=0, intra-block row r=0, col c=0. start_in outside IDLE ignored.
- FETCH: one address per cycle, no stalls. fb_addr_out = (8·block_row + r)·IMG_W + 8·block_col + c; c increments 0..7, then c=0, r+1. Row base kept as a running sum (add IMG_W per row), no multiplier in the address path. After address 64 (r=7,c=7) → DRAIN.
- DRAIN: BRAM_LATENCY cycles while the last reads return, then → WAIT_DONE.
- WAIT_DONE: hold until block_done_in. Then: if block_col < IMG_W/8−1, block_col+1; else block_col=0, block_row+1. Non-final block → FETCH. Final block (col=IMG_W/8−1, row=IMG_H/8−1) → IDLE, frame_done_out pulses, busy_out drops.
- block_done_in ignored in IDLE, FETCH, DRAIN (not latched).
- Valid pipeline: shift register of depth BRAM_LATENCY carrying (issue, is_64th); pixel_valid_out/pixel_last_out are its output; pixel_out = fb_data_in registered-through as needed so it aligns with pixel_valid_out.
- busy_out high in FETCH, DRAIN, WAIT_DONE.
- fb_addr_out held at last issued value outside FETCH.
- rst_in in any state: → IDLE, valid pipeline flushed, no pixel emitted the following cycle, no frame_done_out.

## Timing
- Reset values: fb_addr_out=0, pixel_out=0, pixel_valid_out=0, pixel_last_out=0, block_col_out=0, block_row_out=0, busy_out=0, frame_done_out=0.
- start_in at cycle T → FETCH at T+1, first address at T+1, first pixel_valid_out at T+1+BRAM_LATENCY.
- Each block: 64 consecutive valid cycles, pixel_last_out coincident with 64th.
- block_done_in at cycle D in WAIT_DONE → next block's first address at D+1; frame_done_out at D+1 for final block.
- Minimum per-block period: 64 + BRAM_LATENCY + 1 cycles (done asserted the first WAIT_DONE cycle).
- block_col_out/block_row_out stable from first address through WAIT_DONE of that block.

## Test plan
- Reset: hold rst_in 3 cycles → all outputs at reset values; start_in during reset → no FETCH.
- Single frame, IMG_W=16, IMG_H=16, BRAM_LATENCY=2, model BRAM data=address, block_done_in 5 cycles after each last → pixels in order 0..7,16..23,…,112..119 for block (0,0); block (1,0) starts at 8; 4 blocks, 256 valid pixels, 4 lasts, one frame_done_out.
- Latency: start_in at cycle 10 → first fb_addr_out at 11, first pixel_valid_out at 13, pixel_last_out at 76.
- Early done: block_done_in pulsed during FETCH and DRAIN → ignored, scheduler still waits in WAIT_DONE for a later pulse.
- Reset mid-block: rst_in at 30th pixel → busy_out=0 next cycle, no further pixel_valid_out; fresh start_in restarts at block (0,0), address 0.
- Start while busy: start_in pulsed in WAIT_DONE → ignored, frame completes with exactly IMG_W·IMG_H/64 blocks.

Source files
------------

// File: rtl/jpeg_block_scheduler_if.sv
// Pixel stream between the block scheduler and the encoder datapath.
// The scheduler (master) drives pixels, framing and block position;
// the encoder chain (slave) answers with a pulse when a block is consumed.
interface jpeg_block_scheduler_if #(
    parameter int PIX_WIDTH = 24,
    parameter int COL_W     = 6,
    parameter int ROW_W     = 5
);
    logic [PIX_WIDTH-1:0] pixel;
    logic                 pixel_valid;
    logic                 pixel_last;
    logic                 block_done;
    logic [COL_W-1:0]     block_col;
    logic [ROW_W-1:0]     block_row;

    modport master (
        output pixel,
        output pixel_valid,
        output pixel_last,
        output block_col,
        output block_row,
        input  block_done
    );

    modport slave (
        input  pixel,
        input  pixel_valid,
        input  pixel_last,
        input  block_col,
        input  block_row,
        output block_done
    );
endinterface

// File: rtl/jpeg_block_scheduler.sv
// Walks a raster-order frame buffer as a sequence of 8x8 blocks, issuing one
// read address per cycle, re-timing the returned words into a valid/last
// stream and waiting for the encoder chain to finish each block before
// starting the next one.
module jpeg_block_scheduler #(
    parameter int IMG_W        = 320,
    parameter int IMG_H        = 240,
    parameter int PIX_WIDTH    = 24,
    parameter int ADDR_WIDTH   = 17,
    parameter int BRAM_LATENCY = 2,
    localparam int COL_W = (IMG_W / 8 > 1) ? $clog2(IMG_W / 8) : 1,
    localparam int ROW_W = (IMG_H / 8 > 1) ? $clog2(IMG_H / 8) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    output logic [ADDR_WIDTH-1:0]   fb_addr_out,
    input  logic [PIX_WIDTH-1:0]    fb_data_in,
    jpeg_block_scheduler_if.master  enc,
    output logic                    busy_out,
    output logic                    frame_done_out
);

    localparam int DW = $clog2(BRAM_LATENCY + 1);

    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W / 8 - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_H / 8 - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP  = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] BLK_STEP  = ADDR_WIDTH'(8 * IMG_W);
    localparam logic [ADDR_WIDTH-1:0] COL_STEP  = ADDR_WIDTH'(8);
    localparam logic [DW-1:0]         DRAIN_END = DW'(BRAM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Block position and intra-block pixel counters
    logic [COL_W-1:0]      blk_col;
    logic [ROW_W-1:0]      blk_row;
    logic [2:0]            pix_r;
    logic [2:0]            pix_c;

    // Address bases, all kept as running sums so no multiplier is needed
    logic [ADDR_WIDTH-1:0] blk_row_base;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] col_base;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;

    logic [DW-1:0]         drain_cnt;

    logic [BRAM_LATENCY-1:0] vld_sr;
    logic [BRAM_LATENCY-1:0] lst_sr;

    logic issue;
    logic issue_last;
    logic done_accept;
    logic frame_end;
    logic final_block;
    logic frame_done_q;

    assign final_block = (blk_col == LAST_COL) && (blk_row == LAST_ROW);
    assign cur_addr    = row_base + col_base + ADDR_WIDTH'(pix_c);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        issue_last  = 1'b0;
        done_accept = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start_in) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                issue = 1'b1;
                if (pix_r == 3'd7 && pix_c == 3'd7) begin
                    issue_last = 1'b1;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_END) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (enc.block_done) begin
                    done_accept = 1'b1;
                    if (final_block) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address output: live address while fetching, otherwise the last one issued
    always_comb begin
        fb_addr_out = addr_hold;
        if (issue) begin
            fb_addr_out = cur_addr;
        end
    end

    // Pixel/block counters and the running address bases
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            blk_col      <= '0;
            blk_row      <= '0;
            pix_r        <= '0;
            pix_c        <= '0;
            blk_row_base <= '0;
            row_base     <= '0;
            col_base     <= '0;
            addr_hold    <= '0;
        end else begin
            if (state == IDLE && start_in) begin
                blk_col      <= '0;
                blk_row      <= '0;
                pix_r        <= '0;
                pix_c        <= '0;
                blk_row_base <= '0;
                row_base     <= '0;
                col_base     <= '0;
            end
            if (issue) begin
                addr_hold <= cur_addr;
                pix_c     <= pix_c + 3'd1;
                if (pix_c == 3'd7) begin
                    if (pix_r == 3'd7) begin
                        pix_r    <= '0;
                        row_base <= blk_row_base;
                    end else begin
                        pix_r    <= pix_r + 3'd1;
                        row_base <= row_base + ROW_STEP;
                    end
                end
            end
            if (done_accept) begin
                if (frame_end) begin
                    blk_col      <= '0;
                    blk_row      <= '0;
                    blk_row_base <= '0;
                    row_base     <= '0;
                    col_base     <= '0;
                end else if (blk_col != LAST_COL) begin
                    blk_col  <= blk_col + COL_W'(1);
                    col_base <= col_base + COL_STEP;
                    row_base <= blk_row_base;
                end else begin
                    blk_col      <= '0;
                    col_base     <= '0;
                    blk_row      <= blk_row + ROW_W'(1);
                    blk_row_base <= blk_row_base + BLK_STEP;
                    row_base     <= blk_row_base + BLK_STEP;
                end
            end
        end
    end

    // Counts the cycles spent waiting for the final reads of a block to return
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drain_cnt <= '0;
        end else if (state == DRAIN) begin
            drain_cnt <= drain_cnt + DW'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    // Valid/last shift register matching the frame-buffer read latency
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_sr <= '0;
            lst_sr <= '0;
        end else begin
            vld_sr[0] <= issue;
            lst_sr[0] <= issue_last;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                lst_sr[i] <= lst_sr[i-1];
            end
        end
    end

    // Frame-complete pulse, one cycle after the final block is acknowledged
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
        end
    end

    // Read data already lines up with the valid pipeline; gate it so the
    // stream reads zero whenever no pixel is being presented.
    assign enc.pixel       = vld_sr[BRAM_LATENCY-1] ? fb_data_in : '0;
    assign enc.pixel_valid = vld_sr[BRAM_LATENCY-1];
    assign enc.pixel_last  = lst_sr[BRAM_LATENCY-1];
    assign enc.block_col   = blk_col;
    assign enc.block_row   = blk_row;

    assign busy_out       = (state != IDLE);
    assign frame_done_out = frame_done_q;

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Bench for jpeg_block_scheduler on a 16x16 frame with a 2-cycle frame buffer
// whose contents equal the address. Expected pixels are queued up front and
// a monitor pops and compares every presented pixel.
module tb_jpeg_block_scheduler;

    localparam int IMG_W      = 16;
    localparam int IMG_H      = 16;
    localparam int PIX_WIDTH  = 24;
    localparam int ADDR_WIDTH = 8;
    localparam int LAT        = 2;
    localparam int COL_W      = 1;
    localparam int ROW_W      = 1;

    typedef struct {
        logic [PIX_WIDTH-1:0] data;
        logic                 last;
        logic [COL_W-1:0]     col;
        logic [ROW_W-1:0]     row;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] fb_addr;
    logic [PIX_WIDTH-1:0]  fb_data;
    logic                  busy;
    logic                  frame_done;
    logic                  manual_done = 1'b0;
    logic                  auto_pulse  = 1'b0;
    logic                  auto_en     = 1'b0;

    logic [ADDR_WIDTH-1:0] bram_pipe [LAT];

    exp_t exp_q[$];

    int n_vec   = 0;
    int n_err   = 0;
    int n_valid = 0;
    int n_last  = 0;
    int n_fd    = 0;

    always #5 clk = ~clk;

    jpeg_block_scheduler_if #(.PIX_WIDTH(PIX_WIDTH), .COL_W(COL_W), .ROW_W(ROW_W)) enc_if ();

    assign enc_if.block_done = manual_done | auto_pulse;

    jpeg_block_scheduler #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .PIX_WIDTH   (PIX_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BRAM_LATENCY(LAT)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .fb_addr_out   (fb_addr),
        .fb_data_in    (fb_data),
        .enc           (enc_if),
        .busy_out      (busy),
        .frame_done_out(frame_done)
    );

    // Frame buffer model: word content equals its address, LAT cycles late
    always @(posedge clk) begin
        bram_pipe[0] <= fb_addr;
        for (int i = 1; i < LAT; i++) begin
            bram_pipe[i] <= bram_pipe[i-1];
        end
    end
    assign fb_data = PIX_WIDTH'(bram_pipe[LAT-1]);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue the whole frame in block order: 8x8 pixels per block, raster inside
    task automatic pushFrame();
        exp_t e;
        for (int br = 0; br < IMG_H / 8; br++) begin
            for (int bc = 0; bc < IMG_W / 8; bc++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        e.data = PIX_WIDTH'((8 * br + r) * IMG_W + 8 * bc + c);
                        e.last = (r == 7 && c == 7);
                        e.col  = COL_W'(bc);
                        e.row  = ROW_W'(br);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitFrameDone(input string name);
        int k = 0;
        while (frame_done !== 1'b1 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_frame_done_seen"}, 32'(frame_done), 32'd1);
        checkOutput({name, "_busy_at_frame_done"}, 32'(busy), 32'd0);
    endtask

    // Monitor: every presented pixel is checked against the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (frame_done === 1'b1) n_fd++;
        if (enc_if.pixel_valid === 1'b1) begin
            n_valid++;
            if (enc_if.pixel_last === 1'b1) n_last++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_pixel got=%0h expected=none", enc_if.pixel);
            end else begin
                e = exp_q.pop_front();
                checkOutput("pixel_data", 32'(enc_if.pixel), 32'(e.data));
                checkOutput("pixel_last", 32'(enc_if.pixel_last), 32'(e.last));
                checkOutput("block_col", 32'(enc_if.block_col), 32'(e.col));
                checkOutput("block_row", 32'(enc_if.block_row), 32'(e.row));
            end
        end
    end

    // Downstream model: acknowledge each block 5 cycles after its last pixel
    always begin
        @(negedge clk);
        if (auto_en && enc_if.pixel_last === 1'b1) begin
            repeat (5) @(negedge clk);
            auto_pulse = 1'b1;
            @(negedge clk);
            auto_pulse = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int cnt;

        // Reset held with start asserted
        rst   = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_fb_addr", 32'(fb_addr), 32'd0);
        checkOutput("rst_pixel", 32'(enc_if.pixel), 32'd0);
        checkOutput("rst_valid", 32'(enc_if.pixel_valid), 32'd0);
        checkOutput("rst_last", 32'(enc_if.pixel_last), 32'd0);
        checkOutput("rst_col", 32'(enc_if.block_col), 32'd0);
        checkOutput("rst_row", 32'(enc_if.block_row), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("start_in_reset_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Frame 1: latency, full order, start while busy
        $display("[TB] frame 1: latency and ordering");
        pushFrame();
        auto_en = 1'b1;
        applyStimulus();
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("first_addr", 32'(fb_addr), 32'd0);
        checkOutput("no_valid_t1", 32'(enc_if.pixel_valid), 32'd0);
        @(negedge clk);
        checkOutput("second_addr", 32'(fb_addr), 32'd1);
        checkOutput("no_valid_t2", 32'(enc_if.pixel_valid), 32'd0);
        @(negedge clk);
        checkOutput("first_valid_t3", 32'(enc_if.pixel_valid), 32'd1);
        k = 3;
        while (enc_if.pixel_last !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("first_last_latency", 32'(k), 32'd66);
        @(negedge clk);
        checkOutput("busy_in_wait_done", 32'(busy), 32'd1);
        applyStimulus();
        waitFrameDone("frame1");
        @(negedge clk);
        checkOutput("frame_done_one_cycle", 32'(frame_done), 32'd0);
        checkOutput("frame1_valid_count", 32'(n_valid), 32'd256);
        checkOutput("frame1_last_count", 32'(n_last), 32'd4);
        checkOutput("frame1_fd_count", 32'(n_fd), 32'd1);
        checkOutput("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("idle_after_frame1", 32'(busy), 32'd0);

        // Frame 2: early done pulses in FETCH and DRAIN are ignored
        $display("[TB] frame 2: early block_done");
        pushFrame();
        auto_en = 1'b0;
        applyStimulus();
        repeat (10) @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        k = 0;
        while (enc_if.pixel_last !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("frame2_last_seen", 32'(enc_if.pixel_last), 32'd1);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("early_done_still_busy", 32'(busy), 32'd1);
        checkOutput("early_done_no_valid", 32'(enc_if.pixel_valid), 32'd0);
        checkOutput("addr_held_in_wait", 32'(fb_addr), 32'd119);
        checkOutput("col_held_in_wait", 32'(enc_if.block_col), 32'd0);
        manual_done = 1'b1;
        auto_en     = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        checkOutput("next_block_addr", 32'(fb_addr), 32'd8);
        checkOutput("next_block_col", 32'(enc_if.block_col), 32'd1);
        checkOutput("next_block_row", 32'(enc_if.block_row), 32'd0);
        waitFrameDone("frame2");
        @(negedge clk);
        checkOutput("frame2_valid_count", 32'(n_valid), 32'd512);
        checkOutput("frame2_fd_count", 32'(n_fd), 32'd2);
        checkOutput("frame2_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);

        // Frame 3: reset on the 30th pixel, then a clean restart
        $display("[TB] frame 3: reset mid-block");
        pushFrame();
        applyStimulus();
        cnt = 0;
        k   = 0;
        while (cnt < 30 && k < 300) begin
            @(negedge clk);
            k++;
            if (enc_if.pixel_valid === 1'b1) cnt++;
        end
        checkOutput("reached_30th_pixel", 32'(cnt), 32'd30);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_no_valid", 32'(enc_if.pixel_valid), 32'd0);
        checkOutput("mid_rst_no_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        checkOutput("mid_rst_no_valid_2", 32'(enc_if.pixel_valid), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("after_rst_no_valid", 32'(enc_if.pixel_valid), 32'd0);
        checkOutput("after_rst_col", 32'(enc_if.block_col), 32'd0);
        checkOutput("after_rst_row", 32'(enc_if.block_row), 32'd0);
        pushFrame();
        applyStimulus();
        checkOutput("restart_addr", 32'(fb_addr), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        waitFrameDone("frame4");
        @(negedge clk);
        checkOutput("total_valid_count", 32'(n_valid), 32'd798);
        checkOutput("total_last_count", 32'(n_last), 32'd12);
        checkOutput("total_fd_count", 32'(n_fd), 32'd3);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
